// File: rtl/spy_pkg.sv
// Shared types and default widths for the spy delay-path measurement controller.
package spy_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DLY_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    WAIT,
    SAMPLE,
    CHECK,
    DONE
  } spy_state_e;

endpackage

// File: rtl/spy_trial_timer.sv
// Loadable down-counter shared by the settle and capture-wait phases of a trial.
module spy_trial_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] value_q, value_d;

  // load wins over decrement; the count saturates at zero
  always_comb begin
    value_d = value_q;
    if (load_i)
      value_d = load_val_i;
    else if (dec_i && (value_q != '0))
      value_d = value_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/spy_path_measure_ctrl.sv
// Trial sequencer for a delay-path side-channel sensor: settle, launch an edge,
// wait captureDelay cycles, sample the path output and count in-time arrivals.
module spy_path_measure_ctrl
  import spy_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int DLY_W         = DLY_W_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int PATH_INVERTS  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] trialCount,
  input  logic [DLY_W-1:0] captureDelay,
  output logic             busy,
  output logic             done,
  output logic             resultValid,
  output logic [CNT_W-1:0] hitCount,
  output logic             pathInput,
  input  logic             pathResult
);

  localparam int   SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int   TMR_W   = (DLY_W > SET_W) ? DLY_W : SET_W;
  localparam logic EXP_VAL = (PATH_INVERTS == 0);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);

  spy_state_e       state_q;
  logic [CNT_W-1:0] remain_q;
  logic [CNT_W-1:0] hit_q;
  logic [DLY_W-1:0] dly_q;
  logic             sample_q;
  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic             path_q;

  logic             tmr_ld;
  logic             tmr_dec;
  logic [TMR_W-1:0] tmr_ld_val;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  // Settle loads N-1 and exits on zero; the wait phase loads captureDelay and
  // exits as it passes 1, so a zero delay skips WAIT entirely.
  always_comb begin
    tmr_ld     = 1'b0;
    tmr_dec    = 1'b0;
    tmr_ld_val = SETTLE_LD;
    case (state_q)
      IDLE:    tmr_ld = start && (trialCount != '0);
      SETTLE:  tmr_dec = 1'b1;
      LAUNCH: begin
        tmr_ld     = 1'b1;
        tmr_ld_val = TMR_W'(dly_q);
      end
      WAIT:    tmr_dec = 1'b1;
      CHECK:   tmr_ld = (remain_q != CNT_W'(1));
      default: ;
    endcase
  end

  spy_trial_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_ld),
    .load_val_i (tmr_ld_val),
    .dec_i      (tmr_dec),
    .value_o    (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      hit_q    <= '0;
      dly_q    <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      path_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            remain_q <= trialCount;
            dly_q    <= captureDelay;
            hit_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= (trialCount == '0) ? DONE : SETTLE;
          end
        end
        SETTLE: begin
          // the edge launches as we enter LAUNCH, so sampling lands 1+delay+1 edges later
          if (tmr_zero) begin
            path_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: state_q <= (dly_q == '0) ? SAMPLE : WAIT;
        WAIT: begin
          if (tmr_val == TMR_W'(1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          // single raw flop: the path output is deliberately not synchronised
          sample_q <= pathResult;
          state_q  <= CHECK;
        end
        CHECK: begin
          if (sample_q == EXP_VAL) hit_q <= hit_q + CNT_W'(1);
          remain_q <= remain_q - CNT_W'(1);
          path_q   <= 1'b0;
          state_q  <= (remain_q == CNT_W'(1)) ? DONE : SETTLE;
        end
        DONE: begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign resultValid = valid_q;
  assign hitCount    = hit_q;
  assign pathInput   = path_q;

endmodule
